execute_proc: RTL and testbench
===============================

# execute_proc

Execute stage of the five-stage Y86-64 pipeline, directly downstream of the decode stage. Consumes the E pipeline register fields driven by decode, computes the ALU result, holds and updates the condition codes, and evaluates branch/cmov conditions. Drives the forwarding outputs back into decode, and drives the registered M pipeline fields consumed by the memory stage.

## Interface
Parameters: none. Opcodes, stat codes and register IDs are fixed by the ISA.

Ports:
- clock  in  1  single clock; all state changes on posedge
- reset  in  1  synchronous, active-high
- E_in_code  in  4  instruction code from the E register
- E_in_fun  in  4  function code
- E_val_a  in  64  operand A
- E_val_b  in  64  operand B
- E_val_c  in  64  constant
- E_dst_e  in  4  ALU destination register; 15 = none
- E_dst_m  in  4  memory destination register
- E_stat  in  2  status: 0 AOK, 1 HLT, 2 ADR, 3 INS
- m_stat  in  2  status currently leaving the memory stage
- W_stat  in  2  status in the W register
- M_bub  in  1  inject a bubble into M on the next edge
- e_val_e  out  64  combinational ALU result, forwarded to decode
- e_dst_e  out  4  combinational effective destination, forwarded to decode
- e_cnd  out  1  combinational condition result
- M_stat, M_in_code, M_in_fun  out  2/4/4  registered
- M_val_e, M_val_a  out  64 each  registered ALU result and pass-through operand A
- M_dst_e, M_dst_m  out  4 each  registered
- M_cnd  out  1  registered condition
- cc_zf, cc_sf, cc_of  out  1 each  condition-code register (for debug/verification)

## Operation
- aluA select:
  - E_val_a for codes 2 (cmovXX) and 6 (OPq).
  - E_val_c for codes 3, 4, 5.
  - -8 for codes 8 and 10.
  - +8 for codes 9 and 11.
  - 0 otherwise.
- aluB select:
  - E_val_b for codes 4, 5, 6, 8, 9, 10, 11.
  - 0 for codes 2 and 3, and for all other codes.
- ALU function:
  - For code 6, taken from E_in_fun: 0 add (B+A), 1 sub (B−A), 2 and, 3 xor.
  - For any other code, add.
  - An undefined fun code with code 6 produces add.
- Arithmetic is 64-bit two's complement with wrap-around; no carry is kept.
- Flags:
  - ZF = (result == 0).
  - SF = result[63].
  - OF for add = (A[63]==B[63]) && (R[63]!=A[63]).
  - OF for sub = (A[63]!=B[63]) && (R[63]!=B[63]).
  - OF for and/xor = 0.
- set_cc = (E_in_code==6) && m_stat==0 && W_stat==0 && E_stat==0. The CC register loads the new flags at posedge only when set_cc is high.
- Condition evaluation (fun) uses the current CC register value, not the flags being computed this cycle:
  - 0 always
  - 1 le: (SF^OF)|ZF
  - 2 l: SF^OF
  - 3 e: ZF
  - 4 ne: !ZF
  - 5 ge: !(SF^OF)
  - 6 g: !(SF^OF)&!ZF
  - fun > 6: e_cnd = 0
- e_cnd is meaningful only for codes 2 and 7. For other codes it is forced to 1.
- e_dst_e = 15 when E_in_code==2 && !e_cnd. Otherwise e_dst_e = E_dst_e.
- M register update at posedge, in priority order:
  1. reset
  2. M_bub: loads a bubble (M_stat 0, M_in_code 1, M_in_fun 0, M_dst_e/M_dst_m 15, M_val_e/M_val_a 0, M_cnd 0).
  3. Otherwise: M_stat←E_stat, M_in_code←E_in_code, M_in_fun←E_in_fun, M_val_e←e_val_e, M_val_a←E_val_a, M_dst_e←e_dst_e, M_dst_m←E_dst_m, M_cnd←e_cnd.
- M_bub does not suppress a CC update. Decoupling the CC update from a stalled instruction is done only by gating on status.

## Timing
- Reset values:
  - M register: bubble values as listed above.
  - CC: ZF=1, SF=0, OF=0.
- Reset takes priority over M_bub and over set_cc.
- Latency:
  - e_val_e, e_dst_e and e_cnd are valid in the same cycle the E fields are valid (zero-cycle path).
  - M outputs follow one cycle later.
- CC written by an OPq is visible to a cmov or jXX in the next cycle, i.e. to the following instruction. This produces no extra bubble.
- Simultaneous cases:
  - OPq with m_stat≠0 or W_stat≠0 in the same cycle: CC is held, but M still loads the OPq result.
  - A reset asserted mid-stream discards the in-flight instruction.

## Test plan
- Reset, then check state: M_in_code=1, M_dst_e=15, M_val_e=0, cc_zf=1, cc_sf=0, cc_of=0.
- OPq sub, A=5, B=5 → e_val_e=0; next cycle cc_zf=1, cc_sf=0, M_val_e=0.
- OPq add, A=B=0x7FFF_FFFF_FFFF_FFFF → e_val_e=0xFFFF_FFFF_FFFF_FFFE; next cycle cc_of=1, cc_sf=1, cc_zf=0.
- CC set with SF=1, OF=0, then cmovXX fun 5 (ge), E_dst_e=3 → e_cnd=0, e_dst_e=15. With fun 2 (l) → e_cnd=1, e_dst_e=3.
- Stack arithmetic:
  - pushq, E_val_b=0x100 → e_val_e=0xF8.
  - popq, E_val_b=0x100 → e_val_e=0x108, M_val_a passes E_val_a.
- Status gating and bubble:
  - OPq xor producing 0 with W_stat=2 → CC unchanged.
  - Same input with M_bub=1 → M_in_code=1, M_dst_e=15 next cycle.

Source files
------------

// File: rtl/execute_proc.sv
// Y86-64 execute stage: ALU, condition codes, branch/cmov evaluation,
// forwarding outputs to decode and the registered M pipeline fields.
module execute_proc (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  E_in_code,
  input  logic [3:0]  E_in_fun,
  input  logic [63:0] E_val_a,
  input  logic [63:0] E_val_b,
  input  logic [63:0] E_val_c,
  input  logic [3:0]  E_dst_e,
  input  logic [3:0]  E_dst_m,
  input  logic [1:0]  E_stat,
  input  logic [1:0]  m_stat,
  input  logic [1:0]  W_stat,
  input  logic        M_bub,
  output logic [63:0] e_val_e,
  output logic [3:0]  e_dst_e,
  output logic        e_cnd,
  output logic [1:0]  M_stat,
  output logic [3:0]  M_in_code,
  output logic [3:0]  M_in_fun,
  output logic [63:0] M_val_e,
  output logic [63:0] M_val_a,
  output logic [3:0]  M_dst_e,
  output logic [3:0]  M_dst_m,
  output logic        M_cnd,
  output logic        cc_zf,
  output logic        cc_sf,
  output logic        cc_of
);

  localparam int unsigned W = 64;

  localparam logic [3:0] I_NOP   = 4'd1;
  localparam logic [3:0] I_CMOV  = 4'd2;
  localparam logic [3:0] I_IRMOV = 4'd3;
  localparam logic [3:0] I_RMMOV = 4'd4;
  localparam logic [3:0] I_MRMOV = 4'd5;
  localparam logic [3:0] I_OPQ   = 4'd6;
  localparam logic [3:0] I_JXX   = 4'd7;
  localparam logic [3:0] I_CALL  = 4'd8;
  localparam logic [3:0] I_RET   = 4'd9;
  localparam logic [3:0] I_PUSH  = 4'd10;
  localparam logic [3:0] I_POP   = 4'd11;
  localparam logic [3:0] R_NONE  = 4'hF;
  localparam logic [1:0] S_AOK   = 2'd0;

  typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_XOR} alu_fun_t;

  logic [W-1:0] alu_a, alu_b, alu_r;
  alu_fun_t     alu_fun;
  logic         new_zf, new_sf, new_of;
  logic         set_cc;
  logic         cond;

  // Operand and function selection by instruction class
  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_fun = ALU_ADD;
    case (E_in_code)
      I_CMOV, I_OPQ:             alu_a = E_val_a;
      I_IRMOV, I_RMMOV, I_MRMOV: alu_a = E_val_c;
      I_CALL, I_PUSH:            alu_a = {{(W-4){1'b1}}, 4'b1000};
      I_RET, I_POP:              alu_a = W'(8);
      default:                   alu_a = '0;
    endcase
    case (E_in_code)
      I_RMMOV, I_MRMOV, I_OPQ, I_CALL, I_RET, I_PUSH, I_POP: alu_b = E_val_b;
      default:                                               alu_b = '0;
    endcase
    // Undefined OPq functions fall back to add
    if (E_in_code == I_OPQ && E_in_fun[3:2] == 2'b00)
      alu_fun = alu_fun_t'(E_in_fun[1:0]);
  end

  // ALU and flag generation
  always_comb begin
    alu_r  = '0;
    new_of = 1'b0;
    case (alu_fun)
      ALU_ADD: begin
        alu_r  = alu_b + alu_a;
        new_of = (alu_a[W-1] == alu_b[W-1]) && (alu_r[W-1] != alu_a[W-1]);
      end
      ALU_SUB: begin
        alu_r  = alu_b - alu_a;
        new_of = (alu_a[W-1] != alu_b[W-1]) && (alu_r[W-1] != alu_b[W-1]);
      end
      ALU_AND: alu_r = alu_b & alu_a;
      ALU_XOR: alu_r = alu_b ^ alu_a;
      default: alu_r = alu_b + alu_a;
    endcase
    new_zf = (alu_r == '0);
    new_sf = alu_r[W-1];
  end

  assign e_val_e = alu_r;
  assign set_cc  = (E_in_code == I_OPQ) && (m_stat == S_AOK) &&
                   (W_stat == S_AOK) && (E_stat == S_AOK);

  // Branch/cmov condition from the stored condition codes
  always_comb begin
    cond = 1'b0;
    case (E_in_fun)
      4'd0:    cond = 1'b1;
      4'd1:    cond = (cc_sf ^ cc_of) | cc_zf;
      4'd2:    cond = cc_sf ^ cc_of;
      4'd3:    cond = cc_zf;
      4'd4:    cond = ~cc_zf;
      4'd5:    cond = ~(cc_sf ^ cc_of);
      4'd6:    cond = ~(cc_sf ^ cc_of) & ~cc_zf;
      default: cond = 1'b0;
    endcase
    e_cnd   = (E_in_code == I_CMOV || E_in_code == I_JXX) ? cond : 1'b1;
    e_dst_e = (E_in_code == I_CMOV && !e_cnd) ? R_NONE : E_dst_e;
  end

  // Condition-code register, loaded only by OPq with clean status
  always_ff @(posedge clock) begin
    if (reset) begin
      cc_zf <= 1'b1;
      cc_sf <= 1'b0;
      cc_of <= 1'b0;
    end else if (set_cc) begin
      cc_zf <= new_zf;
      cc_sf <= new_sf;
      cc_of <= new_of;
    end
  end

  // M pipeline register with bubble injection
  always_ff @(posedge clock) begin
    if (reset || M_bub) begin
      M_stat    <= S_AOK;
      M_in_code <= I_NOP;
      M_in_fun  <= 4'd0;
      M_val_e   <= '0;
      M_val_a   <= '0;
      M_dst_e   <= R_NONE;
      M_dst_m   <= R_NONE;
      M_cnd     <= 1'b0;
    end else begin
      M_stat    <= E_stat;
      M_in_code <= E_in_code;
      M_in_fun  <= E_in_fun;
      M_val_e   <= e_val_e;
      M_val_a   <= E_val_a;
      M_dst_e   <= e_dst_e;
      M_dst_m   <= E_dst_m;
      M_cnd     <= e_cnd;
    end
  end

endmodule

// File: tb/tb_execute_proc.sv
// Bench for execute_proc: directed vectors, a reference model checked every
// cycle, and hand-computed literal expectations.
module tb_execute_proc;

  logic        clock, reset;
  logic [3:0]  E_in_code, E_in_fun, E_dst_e, E_dst_m;
  logic [63:0] E_val_a, E_val_b, E_val_c;
  logic [1:0]  E_stat, m_stat, W_stat;
  logic        M_bub;
  logic [63:0] e_val_e, M_val_e, M_val_a;
  logic [3:0]  e_dst_e, M_in_code, M_in_fun, M_dst_e, M_dst_m;
  logic        e_cnd, M_cnd, cc_zf, cc_sf, cc_of;
  logic [1:0]  M_stat;

  int checks = 0;
  int passes = 0;

  execute_proc dut (
    .clock(clock), .reset(reset),
    .E_in_code(E_in_code), .E_in_fun(E_in_fun),
    .E_val_a(E_val_a), .E_val_b(E_val_b), .E_val_c(E_val_c),
    .E_dst_e(E_dst_e), .E_dst_m(E_dst_m),
    .E_stat(E_stat), .m_stat(m_stat), .W_stat(W_stat), .M_bub(M_bub),
    .e_val_e(e_val_e), .e_dst_e(e_dst_e), .e_cnd(e_cnd),
    .M_stat(M_stat), .M_in_code(M_in_code), .M_in_fun(M_in_fun),
    .M_val_e(M_val_e), .M_val_a(M_val_a),
    .M_dst_e(M_dst_e), .M_dst_m(M_dst_m), .M_cnd(M_cnd),
    .cc_zf(cc_zf), .cc_sf(cc_sf), .cc_of(cc_of)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [63:0] val;
    logic        zf, sf, of, cnd;
    logic [3:0]  dst;
  } res_t;

  // Instruction semantics from the ISA point of view
  function automatic res_t model(input logic [3:0] code, fun,
                                 input logic [63:0] a, b, c,
                                 input logic [3:0] dst,
                                 input logic zf, sf, of);
    res_t r;
    logic [64:0] wide;
    logic taken;
    r = '0;
    wide = '0;
    case (code)
      4'd2:        r.val = a;
      4'd3:        r.val = c;
      4'd4, 4'd5:  r.val = b + c;
      4'd8, 4'd10: r.val = b - 64'd8;
      4'd9, 4'd11: r.val = b + 64'd8;
      4'd6: begin
        if (fun == 4'd1) begin
          wide  = {b[63], b} - {a[63], a};
          r.val = wide[63:0];
          r.of  = wide[64] != wide[63];
        end else if (fun == 4'd2) begin
          r.val = a & b;
        end else if (fun == 4'd3) begin
          r.val = a ^ b;
        end else begin
          wide  = {a[63], a} + {b[63], b};
          r.val = wide[63:0];
          r.of  = wide[64] != wide[63];
        end
      end
      default: r.val = 64'd0;
    endcase
    r.zf = (r.val == 64'd0);
    r.sf = r.val[63];
    case (fun)
      4'd0: taken = 1'b1;
      4'd1: taken = (sf != of) || zf;
      4'd2: taken = (sf != of);
      4'd3: taken = zf;
      4'd4: taken = !zf;
      4'd5: taken = (sf == of);
      4'd6: taken = (sf == of) && !zf;
      default: taken = 1'b0;
    endcase
    r.cnd = (code == 4'd2 || code == 4'd7) ? taken : 1'b1;
    r.dst = (code == 4'd2 && !taken) ? 4'hF : dst;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else
      passes++;
  endtask

  // Model state: expected M register and condition codes
  logic        mv = 1'b0;
  logic        mzf, msf, mof;
  logic [1:0]  x_stat;
  logic [3:0]  x_code, x_fun, x_dst_e, x_dst_m;
  logic [63:0] x_val_e, x_val_a;
  logic        x_cnd;

  always @(posedge clock) begin
    res_t r;
    r = model(E_in_code, E_in_fun, E_val_a, E_val_b, E_val_c, E_dst_e, mzf, msf, mof);
    if (reset || M_bub) begin
      x_stat = 2'd0; x_code = 4'd1; x_fun = 4'd0; x_val_e = 64'd0;
      x_val_a = 64'd0; x_dst_e = 4'hF; x_dst_m = 4'hF; x_cnd = 1'b0;
    end else begin
      x_stat = E_stat; x_code = E_in_code; x_fun = E_in_fun; x_val_e = r.val;
      x_val_a = E_val_a; x_dst_e = r.dst; x_dst_m = E_dst_m; x_cnd = r.cnd;
    end
    if (reset) begin
      mzf = 1'b1; msf = 1'b0; mof = 1'b0;
    end else if (E_in_code == 4'd6 && E_stat == 2'd0 && m_stat == 2'd0 && W_stat == 2'd0) begin
      mzf = r.zf; msf = r.sf; mof = r.of;
    end
    mv = 1'b1;
  end

  // Every-cycle comparison against the model
  always @(negedge clock) begin
    res_t r;
    if (mv) begin
      r = model(E_in_code, E_in_fun, E_val_a, E_val_b, E_val_c, E_dst_e, mzf, msf, mof);
      chk("m_e_val_e", e_val_e, r.val);
      chk("m_e_dst_e", 64'(e_dst_e), 64'(r.dst));
      chk("m_e_cnd", 64'(e_cnd), 64'(r.cnd));
      chk("m_cc", {61'd0, cc_zf, cc_sf, cc_of}, {61'd0, mzf, msf, mof});
      chk("m_M_ctl", {50'd0, M_stat, M_in_code, M_in_fun, M_dst_e, M_dst_m},
          {50'd0, x_stat, x_code, x_fun, x_dst_e, x_dst_m});
      chk("m_M_val_e", M_val_e, x_val_e);
      chk("m_M_val_a", M_val_a, x_val_a);
      chk("m_M_cnd", 64'(M_cnd), 64'(x_cnd));
    end
  end

  task automatic drive(input logic [3:0] code, fun, input logic [63:0] a, b, c,
                       input logic [3:0] de);
    E_in_code = code; E_in_fun = fun; E_val_a = a; E_val_b = b; E_val_c = c;
    E_dst_e = de; E_dst_m = 4'hF;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; M_bub = 1'b0; E_stat = 2'd0; m_stat = 2'd0; W_stat = 2'd0;
    drive(4'd1, 4'd0, 64'd0, 64'd0, 64'd0, 4'hF);
    next_cycle();
    next_cycle();
    chk("rst_M_in_code", 64'(M_in_code), 64'd1);
    chk("rst_M_dst_e", 64'(M_dst_e), 64'hF);
    chk("rst_M_val_e", M_val_e, 64'd0);
    chk("rst_cc", {61'd0, cc_zf, cc_sf, cc_of}, 64'b100);
    reset = 1'b0;

    drive(4'd6, 4'd1, 64'd5, 64'd5, 64'd0, 4'd2); #1;
    chk("sub_e_val_e", e_val_e, 64'd0);
    next_cycle();
    chk("sub_zf", 64'(cc_zf), 64'd1);
    chk("sub_sf", 64'(cc_sf), 64'd0);
    chk("sub_M_val_e", M_val_e, 64'd0);

    drive(4'd6, 4'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 4'd2); #1;
    chk("add_e_val_e", e_val_e, 64'hFFFF_FFFF_FFFF_FFFE);
    next_cycle();
    chk("add_cc", {61'd0, cc_zf, cc_sf, cc_of}, 64'b011);

    drive(4'd6, 4'd1, 64'd1, 64'd0, 64'd0, 4'd2);
    next_cycle();
    chk("neg_cc", {61'd0, cc_zf, cc_sf, cc_of}, 64'b010);

    drive(4'd2, 4'd5, 64'h55, 64'd0, 64'd0, 4'd3); #1;
    chk("cmov_ge_cnd", 64'(e_cnd), 64'd0);
    chk("cmov_ge_dst", 64'(e_dst_e), 64'hF);
    next_cycle();
    chk("cmov_ge_M_dst_e", 64'(M_dst_e), 64'hF);

    drive(4'd2, 4'd2, 64'h55, 64'd0, 64'd0, 4'd3); #1;
    chk("cmov_l_cnd", 64'(e_cnd), 64'd1);
    chk("cmov_l_dst", 64'(e_dst_e), 64'd3);
    chk("cmov_l_val", e_val_e, 64'h55);
    next_cycle();

    drive(4'd7, 4'd7, 64'd0, 64'd0, 64'h40, 4'hF); #1;
    chk("jxx_badfun_cnd", 64'(e_cnd), 64'd0);
    next_cycle();

    drive(4'd10, 4'd0, 64'h77, 64'h100, 64'd0, 4'd4); #1;
    chk("push_e_val_e", e_val_e, 64'hF8);
    next_cycle();

    drive(4'd11, 4'd0, 64'h1234, 64'h100, 64'd0, 4'd4); #1;
    chk("pop_e_val_e", e_val_e, 64'h108);
    next_cycle();
    chk("pop_M_val_a", M_val_a, 64'h1234);
    chk("pop_M_val_e", M_val_e, 64'h108);

    W_stat = 2'd2;
    drive(4'd6, 4'd3, 64'hAB, 64'hAB, 64'd0, 4'd5); #1;
    chk("xor_e_val_e", e_val_e, 64'd0);
    next_cycle();
    chk("xor_gated_cc", {61'd0, cc_zf, cc_sf, cc_of}, 64'b010);
    chk("xor_gated_M_code", 64'(M_in_code), 64'd6);

    M_bub = 1'b1;
    next_cycle();
    chk("bub_M_code", 64'(M_in_code), 64'd1);
    chk("bub_M_dst_e", 64'(M_dst_e), 64'hF);
    chk("bub_gated_cc", 64'(cc_zf), 64'd0);

    W_stat = 2'd0;
    next_cycle();
    chk("bub_cc_update", {61'd0, cc_zf, cc_sf, cc_of}, 64'b100);
    M_bub = 1'b0;

    drive(4'd6, 4'd9, 64'd3, 64'd4, 64'd0, 4'd6); #1;
    chk("opq_undef_add", e_val_e, 64'd7);
    next_cycle();
    chk("opq_undef_cc", {61'd0, cc_zf, cc_sf, cc_of}, 64'b000);

    drive(4'd5, 4'd0, 64'd0, 64'h20, 64'h10, 4'hF); #1;
    chk("mrmov_e_val_e", e_val_e, 64'h30);
    next_cycle();

    E_stat = 2'd2;
    drive(4'd6, 4'd1, 64'd5, 64'd5, 64'd0, 4'd1);
    next_cycle();
    chk("estat_gated_zf", 64'(cc_zf), 64'd0);
    chk("estat_M_stat", 64'(M_stat), 64'd2);
    E_stat = 2'd0;

    reset = 1'b1;
    drive(4'd6, 4'd1, 64'd1, 64'd0, 64'd0, 4'd2);
    next_cycle();
    chk("midrst_M_code", 64'(M_in_code), 64'd1);
    chk("midrst_cc", {61'd0, cc_zf, cc_sf, cc_of}, 64'b100);
    reset = 1'b0;

    drive(4'd0, 4'd0, 64'd0, 64'd0, 64'd0, 4'hF);
    next_cycle();
    next_cycle();
    @(negedge clock);
    #1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
